sevenseg_scan_driver: RTL and testbench

// - Consumes the four BCD digits from the stopwatch (min, sec-tens, sec-units, tenths) and drives a 4-digit

---
 rtl/sevenseg_pkg.sv | 26 ++
 rtl/sevenseg_bcd_to_7seg.sv | 28 ++
 rtl/sevenseg_scan_driver.sv | 125 ++++++++++++
 tb/tb_sevenseg_scan_driver.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/sevenseg_pkg.sv
// Shared constants for the 4-digit multiplexed 7-segment scan driver.
// Segment codes are active-low {g,f,e,d,c,b,a}; anodes are active-low.
package sevenseg_pkg;

    localparam logic [6:0] SEG_0    = 7'b1000000;
    localparam logic [6:0] SEG_1    = 7'b1111001;
    localparam logic [6:0] SEG_2    = 7'b0100100;
    localparam logic [6:0] SEG_3    = 7'b0110000;
    localparam logic [6:0] SEG_4    = 7'b0011001;
    localparam logic [6:0] SEG_5    = 7'b0010010;
    localparam logic [6:0] SEG_6    = 7'b0000010;
    localparam logic [6:0] SEG_7    = 7'b1111000;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_9    = 7'b0010000;
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_OFF  = 7'b1111111;

    // Digit index: 0 is the rightmost position on the display.
    localparam logic [1:0] IDX_TENTHS = 2'd0;
    localparam logic [1:0] IDX_SU     = 2'd1;
    localparam logic [1:0] IDX_ST     = 2'd2;
    localparam logic [1:0] IDX_MIN    = 2'd3;

    localparam logic [3:0] AN_OFF = 4'b1111;

endpackage

// File: rtl/sevenseg_bcd_to_7seg.sv
// Combinational BCD to active-low 7-segment decoder.
// Values 10..15 are not valid BCD and are shown as a dash so bad data is visible.
module bcd_to_7seg
    import sevenseg_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    // Table lookup; the default arm covers every non-BCD code.
    always_comb begin
        o_seg = SEG_DASH;
        case (i_bcd)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/sevenseg_scan_driver.sv
// Time-multiplexed driver for a 4-digit common-anode 7-segment display.
// Digits are snapshotted once per frame (when the index wraps 3->0) so a
// frame never mixes old and new values. Each slot begins with a short
// all-anodes-off window to suppress ghosting. All outputs are registered.
module sevenseg_scan_driver
    import sevenseg_pkg::*;
#(
    parameter int REFRESH_DIV  = 100_000,
    parameter int BLANK_CYCLES = 1_000
)(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] digit_min,
    input  logic [3:0] digit_st,
    input  logic [3:0] digit_su,
    input  logic [3:0] digit_tenths,
    input  logic       blank_lead,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_tick
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);

    logic [CW-1:0] r_cnt;
    logic [1:0]    r_idx;
    logic [3:0]    r_sh_min;
    logic [3:0]    r_sh_st;
    logic [3:0]    r_sh_su;
    logic [3:0]    r_sh_tenths;
    logic [3:0]    r_an;
    logic [6:0]    r_seg;
    logic          r_dp;
    logic          r_tick;

    logic          w_slot_end;
    logic          w_frame_end;
    logic          w_blank;
    logic          w_lead_off;
    logic [3:0]    w_digit;
    logic [6:0]    w_seg;
    logic [3:0]    w_an_on;

    assign w_slot_end  = (r_cnt == CNT_LAST);
    assign w_frame_end = w_slot_end && (r_idx == IDX_MIN);
    assign w_blank     = (r_cnt < CNT_BLANK);
    // blank_lead is used live; only the digit values are frame-coherent.
    assign w_lead_off  = blank_lead && (r_sh_min == 4'd0) && (r_idx == IDX_MIN);
    assign w_an_on     = ~(4'b0001 << r_idx);

    // Select the shadowed digit for the current slot.
    always_comb begin
        w_digit = r_sh_tenths;
        case (r_idx)
            IDX_TENTHS: w_digit = r_sh_tenths;
            IDX_SU:     w_digit = r_sh_su;
            IDX_ST:     w_digit = r_sh_st;
            IDX_MIN:    w_digit = r_sh_min;
            default:    w_digit = r_sh_tenths;
        endcase
    end

    bcd_to_7seg u_dec (
        .i_bcd (w_digit),
        .o_seg (w_seg)
    );

    // Slot counter wraps by compare, so it never overflows.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_cnt <= '0;
        else if (w_slot_end) r_cnt <= '0;
        else r_cnt <= r_cnt + 1'b1;
    end

    // Digit index advances once per slot; 2-bit wrap gives 3->0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_idx <= IDX_TENTHS;
        else if (w_slot_end) r_idx <= r_idx + 2'd1;
    end

    // Shadow registers capture all four digits together at the frame boundary.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sh_min    <= 4'd0;
            r_sh_st     <= 4'd0;
            r_sh_su     <= 4'd0;
            r_sh_tenths <= 4'd0;
        end else if (w_frame_end) begin
            r_sh_min    <= digit_min;
            r_sh_st     <= digit_st;
            r_sh_su     <= digit_su;
            r_sh_tenths <= digit_tenths;
        end
    end

    // Output registers: one cycle behind the counter/index they reflect.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_an   <= AN_OFF;
            r_seg  <= SEG_OFF;
            r_dp   <= 1'b1;
            r_tick <= 1'b0;
        end else begin
            r_tick <= w_frame_end;
            if (w_blank || w_lead_off) begin
                r_an  <= AN_OFF;
                r_seg <= SEG_OFF;
                r_dp  <= 1'b1;
            end else begin
                r_an  <= w_an_on;
                r_seg <= w_seg;
                r_dp  <= (r_idx != IDX_SU);
            end
        end
    end

    assign an         = r_an;
    assign seg        = r_seg;
    assign dp         = r_dp;
    assign frame_tick = r_tick;

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Bench for sevenseg_scan_driver with REFRESH_DIV=8, BLANK_CYCLES=2.
// A reference model derives the expected display from the number of clock
// edges since reset release; a monitor compares every cycle.
module tb_sevenseg_scan_driver;

    localparam int DIV   = 8;
    localparam int BLANK = 2;
    localparam int FRAME = 4 * DIV;

    logic       clk;
    logic       rst;
    logic [3:0] digit_min;
    logic [3:0] digit_st;
    logic [3:0] digit_su;
    logic [3:0] digit_tenths;
    logic       blank_lead;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame_tick;

    int total;
    int bad;
    string phase;

    logic [6:0]  dec_tab [16];
    logic [12:0] exp_q [$];

    sevenseg_scan_driver #(
        .REFRESH_DIV  (DIV),
        .BLANK_CYCLES (BLANK)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .digit_min    (digit_min),
        .digit_st     (digit_st),
        .digit_su     (digit_su),
        .digit_tenths (digit_tenths),
        .blank_lead   (blank_lead),
        .an           (an),
        .seg          (seg),
        .dp           (dp),
        .frame_tick   (frame_tick)
    );

    // clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        dec_tab[0]  = 7'b1000000; dec_tab[1]  = 7'b1111001;
        dec_tab[2]  = 7'b0100100; dec_tab[3]  = 7'b0110000;
        dec_tab[4]  = 7'b0011001; dec_tab[5]  = 7'b0010010;
        dec_tab[6]  = 7'b0000010; dec_tab[7]  = 7'b1111000;
        dec_tab[8]  = 7'b0000000; dec_tab[9]  = 7'b0010000;
        for (int k = 10; k < 16; k++) dec_tab[k] = 7'b0111111;
    end

    // Reference model: n counts edges since reset release. The display seen
    // after edge n describes slot position n-1; shadow digits are the values
    // present at edges that are multiples of one frame.
    int         n;
    logic [3:0] m_sh [4];
    initial begin
        n = 0;
        for (int k = 0; k < 4; k++) m_sh[k] = 4'd0;
        forever begin
            @(posedge clk);
            if (!rst) begin
                n = 0;
                for (int k = 0; k < 4; k++) m_sh[k] = 4'd0;
                exp_q.push_back({4'b1111, 7'b1111111, 1'b1, 1'b0});
            end else begin
                int p, c, i;
                logic [3:0] e_an;
                logic [6:0] e_seg;
                logic       e_dp;
                logic       e_tick;
                n++;
                p = n - 1;
                c = p % DIV;
                i = (p / DIV) % 4;
                e_tick = (n % FRAME) == 0;
                if (c < BLANK || (blank_lead && m_sh[3] == 4'd0 && i == 3)) begin
                    e_an = 4'b1111; e_seg = 7'b1111111; e_dp = 1'b1;
                end else begin
                    e_an = 4'b1111;
                    e_an[i] = 1'b0;
                    e_seg = dec_tab[m_sh[i]];
                    e_dp = (i == 1) ? 1'b0 : 1'b1;
                end
                if (e_tick) begin
                    m_sh[0] = digit_tenths;
                    m_sh[1] = digit_su;
                    m_sh[2] = digit_st;
                    m_sh[3] = digit_min;
                end
                exp_q.push_back({e_an, e_seg, e_dp, e_tick});
            end
        end
    end

    // Monitor: pop one expectation per cycle, compare away from the edge.
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                logic [12:0] e;
                e = exp_q.pop_front();
                total++;
                if ({an, seg, dp, frame_tick} !== e) begin
                    bad++;
                    $display("FAIL %s t=%0t: got an=%b seg=%b dp=%b tick=%b want an=%b seg=%b dp=%b tick=%b",
                             phase, $time, an, seg, dp, frame_tick, e[12:9], e[8:2], e[1], e[0]);
                end
            end
        end
    end

    // driver tasks
    task automatic cycles(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic set_digits(input logic [3:0] mn, input logic [3:0] st,
                              input logic [3:0] su, input logic [3:0] tn);
        digit_min = mn; digit_st = st; digit_su = su; digit_tenths = tn;
    endtask

    // Wait (at negedges) for frame_tick, bounded; returns cycles waited.
    task automatic wait_tick(input int budget, output int waited);
        waited = 0;
        while (frame_tick !== 1'b1 && waited < budget) begin
            @(negedge clk);
            waited++;
        end
        if (frame_tick !== 1'b1) begin
            total++; bad++;
            $display("FAIL %s wait_tick: no frame_tick within %0d cycles", phase, budget);
        end
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    initial begin
        int w;
        int an3_on;
        total = 0;
        bad = 0;
        phase = "reset";
        rst = 1'b0;
        blank_lead = 1'b0;
        set_digits(4'd1, 4'd2, 4'd3, 4'd4);
        cycles(5);
        rst = 1'b1;

        // scan order and tick period
        phase = "scan";
        wait_tick(3 * FRAME, w);
        @(negedge clk);
        wait_tick(2 * FRAME, w);
        check("tick_period", w + 1, FRAME);

        // frame coherence: change tenths mid index-1 slot
        phase = "coherence";
        cycles(DIV + 3);
        digit_tenths = 4'd7;
        cycles(2 * FRAME);

        // non-BCD seconds-tens
        phase = "non_bcd";
        digit_st = 4'hB;
        cycles(2 * FRAME);

        // leading blank
        phase = "lead_blank";
        digit_min = 4'd0;
        blank_lead = 1'b1;
        wait_tick(2 * FRAME, w);
        an3_on = 0;
        for (int k = 0; k < 3 * FRAME; k++) begin
            @(negedge clk);
            if (an[3] == 1'b0) an3_on++;
        end
        check("lead_blank_an3", an3_on, 0);
        phase = "lead_shown";
        blank_lead = 1'b0;
        cycles(FRAME + 2);

        // inputs change at the edge that snapshots them
        phase = "boundary";
        wait_tick(2 * FRAME, w);
        cycles(FRAME - 1);
        set_digits(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                   4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        cycles(FRAME + 4);

        // async reset mid-slot, no clock edge needed
        phase = "async_rst";
        w = 0;
        while (an === 4'b1111 && w < 2 * DIV) begin
            @(negedge clk);
            w++;
        end
        #2 rst = 1'b0;
        #1 check("async_rst_outputs", {an, seg, dp, frame_tick}, {4'b1111, 7'b1111111, 1'b1, 1'b0});
        cycles(3);
        rst = 1'b1;
        phase = "after_rst";
        cycles(2 * FRAME);

        // randomized traffic
        phase = "random";
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if ($urandom_range(0, 9) == 0)
                set_digits(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                           4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            if ($urandom_range(0, 4) == 0) digit_min = 4'd0;
            if ($urandom_range(0, 29) == 0) blank_lead = 1'($urandom_range(0, 1));
        end

        cycles(3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
